serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder.sv | 108 ++++++++++
 tb/tb_serial_chunk_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle adder/subtractor that adds one
// CHUNK-bit slice per clock with a registered ripple carry.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             c_msb;

    // Current slice sum; partial sums shift into acc from the top so the
    // LSB slice lands at bit 0 once all slices are in.
    always_comb begin
        a_sl     = a_q[cnt*CHUNK +: CHUNK];
        b_sl     = b_q[cnt*CHUNK +: CHUNK];
        slice    = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        acc_next = WIDTH'({slice[CHUNK-1:0], acc} >> CHUNK);
        last     = (cnt == CW'(NCHUNK - 1));
        c_msb    = slice[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    end

    // Control FSM, operand capture, slice accumulation and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= A;
                        b_q   <= Sub ? ~B : B;
                        carry <= Sub | Cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= slice[CHUNK];
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        S     <= acc_next;
                        Cout  <= slice[CHUNK];
                        Ovf   <= c_msb ^ slice[CHUNK];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: vector table, protocol corner cases and
// random runs at three WIDTH/CHUNK configurations.
module tb_serial_chunk_adder;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Main instance (16,4)
    logic        rst_n, start, cin, sub;
    logic [15:0] a, b, s;
    logic        busy, done, cout, ovf;
    logic [17:0] q[$];
    logic [15:0] prev_s;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .busy(busy), .done(done), .S(s),
        .Cout(cout), .Ovf(ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    // Reference: {ovf, cout, s}
    function automatic logic [17:0] ref16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] full;
        logic        ov;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + 17'(sb | ci);
        ov   = (x[15] == yy[15]) && (full[15] != x[15]);
        return {ov, full};
    endfunction

    task automatic pop_cmp(input string nm);
        logic [17:0] e;
        if (q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'(1), 32'(0));
            return;
        end
        e = q.pop_front();
        chk({nm, "_S"}, 32'(s), 32'(e[15:0]));
        chk({nm, "_Cout"}, 32'(cout), 32'(e[16]));
        chk({nm, "_Ovf"}, 32'(ovf), 32'(e[17]));
        prev_s = e[15:0];
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        sub   = v.sub;
        start = 1'b1;
        q.push_back({v.ovf, v.cout, v.s});
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_done", 32'(done), 32'(0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) chk("hold_S", 32'(s), 32'(prev_s));
            chk("run_busy", 32'(busy), 32'(k != 4));
            chk("run_done", 32'(done), 32'(k == 4));
        end
        pop_cmp("vec");
        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    // Random-operand instances at (16,16) and (8,1)
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int W = (g == 0) ? 16 : 8;
        localparam int C = (g == 0) ? 16 : 1;
        localparam int N = W / C;
        logic         r_rst_n, r_start, r_cin, r_sub;
        logic         r_busy, r_done, r_cout, r_ovf;
        logic [W-1:0] r_a, r_b, r_s;
        logic [W+1:0] r_q[$];
        logic         fin;

        serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst_n(r_rst_n), .start(r_start), .A(r_a),
            .B(r_b), .Cin(r_cin), .Sub(r_sub), .busy(r_busy),
            .done(r_done), .S(r_s), .Cout(r_cout), .Ovf(r_ovf)
        );

        initial begin
            logic [W-1:0] bb;
            logic [W:0]   full;
            logic [W+1:0] e;
            fin     = 1'b0;
            r_rst_n = 1'b0;
            r_start = 1'b0;
            r_a     = '0;
            r_b     = '0;
            r_cin   = 1'b0;
            r_sub   = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            r_rst_n = 1'b1;
            for (int n = 0; n < 25; n++) begin
                @(negedge clk);
                r_a   = W'($urandom);
                r_b   = W'($urandom);
                r_cin = 1'($urandom);
                r_sub = 1'($urandom);
                if (n == 0) begin
                    r_a   = '1;
                    r_b   = W'(1);
                    r_cin = 1'b0;
                    r_sub = 1'b0;
                end
                r_start = 1'b1;
                bb   = r_sub ? ~r_b : r_b;
                full = {1'b0, r_a} + {1'b0, bb} + (W+1)'(r_sub | r_cin);
                e    = {(r_a[W-1] == bb[W-1]) && (full[W-1] != r_a[W-1]),
                        full};
                r_q.push_back(e);
                @(posedge clk);
                #1 r_start = 1'b0;
                chk("rand_busy", 32'(r_busy), 32'(1));
                for (int k = 1; k <= N; k++) begin
                    @(posedge clk);
                    #1;
                    chk("rand_done", 32'(r_done), 32'(k == N));
                end
                e = r_q.pop_front();
                chk("rand_S", 32'(r_s), 32'(e[W-1:0]));
                chk("rand_Cout", 32'(r_cout), 32'(e[W]));
                chk("rand_Ovf", 32'(r_ovf), 32'(e[W+1]));
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            fin = 1'b1;
        end
    end

    vec_t vt[8];

    initial begin
        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        prev_s = 16'h0000;
        rst_n  = 1'b0;
        start  = 1'b1;
        a      = 16'h1234;
        b      = 16'h1111;
        cin    = 1'b0;
        sub    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_S", 32'(s), 32'(0));
        chk("rst_Cout", 32'(cout), 32'(0));
        chk("rst_Ovf", 32'(ovf), 32'(0));
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // start held high, operands changed during RUN, back-to-back
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        q.push_back(ref16(a, b, cin, sub));
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        b = 16'h5555;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("b2b1_done", 32'(done), 32'(k == 4));
        end
        pop_cmp("b2b1");
        q.push_back(ref16(a, b, cin, sub));
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) start = 1'b0;
            chk("b2b2_busy", 32'(busy), 32'(j != 5));
            chk("b2b2_done", 32'(done), 32'(j == 5));
        end
        pop_cmp("b2b2");

        // reset during the second RUN cycle aborts with no done
        @(negedge clk);
        a     = 16'h00FF;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_S", 32'(s), 32'(0));
        chk("abort_Cout", 32'(cout), 32'(0));
        chk("abort_Ovf", 32'(ovf), 32'(0));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("abort_nodone", 32'(done), 32'(0));
        end
        prev_s = 16'h0000;
        run_vec(vt[2]);

        begin
            int t;
            t = 0;
            while (!(g_rand[0].fin && g_rand[1].fin) && t < 5000) begin
                @(posedge clk);
                t++;
            end
            chk("rand_finished", 32'(g_rand[0].fin && g_rand[1].fin),
                32'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
